pixel_stream_sink: RTL
======================

Name: pixel_stream_sink

Overview:
- Receiving end of the raster pixel stream: per-pixel data with first/lastx/valid framing, ready backpressure.
- Checks the frame framing and converts accepted beats into linear framebuffer writes (wr_en/wr_addr/wr_data) to the frame-store port, which applies its own backpressure.
- Recovers from framing errors by dropping until the next first.

Parameters:
- X_SIZE, 1024, pixels per line.
- Y_SIZE, 1024, lines per frame.
- DATA_W, 24, pixel data width (RGB888).
- ADDR_W, 20, framebuffer word address width; must satisfy 2^ADDR_W >= X_SIZE*Y_SIZE.

Ports:
- clk  in  1  clock.
- resetn  in  1  synchronous, active-low reset.
- s_data  in  DATA_W  pixel data.
- s_first  in  1  start-of-frame marker, set on the first pixel of a frame.
- s_lastx  in  1  end-of-line marker, set on the last pixel of each line.
- s_valid  in  1  beat valid.
- s_ready  out  1  sink can accept a beat.
- wr_en  out  1  framebuffer write request.
- wr_addr  out  ADDR_W  word address, row*X_SIZE+col.
- wr_data  out  DATA_W  write data.
- wr_ready  in  1  framebuffer accepts the request this cycle.
- frame_done  out  1  one-cycle pulse when the final pixel of a frame is written.
- err_pulse  out  1  one-cycle pulse on each framing error.
- err_count  out  16  saturating framing-error counter.

Behaviour:
- Handshake rules:
  - A beat is accepted when s_valid && s_ready.
  - A write completes when wr_en && wr_ready.
  - Once wr_en is asserted, wr_en, wr_addr and wr_data hold stable until wr_ready.
- Buffering:
  - 2-entry skid FIFO between the input and the write port.
  - s_ready is registered: s_ready=1 iff FIFO occupancy after this cycle's push/pop is < 2.
  - Minimum latency from acceptance to wr_en is 1 cycle.
  - Full throughput: 1 pixel/cycle when wr_ready is held high.
- Address generation:
  - col and row counters sit at the acceptance side.
  - Address col+row*X_SIZE is computed incrementally: a running base address is incremented, not multiplied.
  - The address is stored in the FIFO with the data.
- FSM (evaluated on accepted beats only):
  - WAIT_SOF: discard beats until s_first=1. On a first beat: col=0, row=0, push the pixel, go to ACTIVE. A non-first beat is discarded silently, with no error.
  - ACTIVE, normal beat: push the pixel and advance col.
    - At col==X_SIZE-1 with s_lastx=1: col=0, row+1.
    - At row==Y_SIZE-1 && col==X_SIZE-1: tag the entry as last-of-frame and go to WAIT_SOF.
  - ACTIVE, error conditions; each one means err_pulse, err_count+1, beat discarded:
    - s_lastx=1 with col!=X_SIZE-1 (early EOL) -> go to WAIT_SOF.
    - col==X_SIZE-1 with s_lastx=0 (missing EOL) -> go to WAIT_SOF.
    - s_first=1 (SOF mid-frame) -> no discard of this beat. Restart: col=0, row=0, push the pixel as address 0, stay in ACTIVE.
  - Simultaneous s_first and s_lastx with X_SIZE==1 is legal.
- Outputs:
  - frame_done pulses in the cycle the tagged last-of-frame write completes (wr_en&&wr_ready).
  - err_count saturates at 16'hFFFF.
- Reset state:
  - s_ready=0; it rises the cycle after resetn goes high.
  - wr_en=0, wr_addr=0, wr_data=0, frame_done=0, err_pulse=0, err_count=0.
  - FIFO empty, FSM in WAIT_SOF.
- Reset mid-frame flushes the FIFO, drops any pending write, and returns to WAIT_SOF.

Optional Feature:
- Macro: PIXEL_SINK_DOUBLE_BUFFER_EN.
- When defined:
  - Extra output fb_sel (1 bit, reset 0) and extra input swap_ok (1 bit).
  - wr_addr is ADDR_W+1 bits, with the MSB equal to the bank being written.
  - On frame_done, a swap is requested. fb_sel toggles when swap_ok=1, in the same cycle or later.
  - Until fb_sel has toggled, the next frame's first beat is held off: s_ready=0 while in WAIT_SOF with a swap pending.
- When undefined: no fb_sel, no swap_ok, and wr_addr is ADDR_W bits, single bank.

Test Plan (X_SIZE=4, Y_SIZE=3, DATA_W=8):
- Clean frame: first on beat 0, lastx on every 4th beat, data 0..11, wr_ready=1 -> writes addr 0..11 with data 0..11 in order, one frame_done after addr 11, err_count=0.
- Backpressure: same frame, wr_ready toggling 1,0,0,1,... -> wr_addr/wr_data stable while wr_ready=0; s_ready drops when 2 entries are pending; no beat lost or duplicated; 12 writes total.
- Early EOL: lastx on the 3rd beat of row 1 -> err_pulse once, err_count=1, later beats dropped until the next first; the next clean frame writes addr 0..11.
- SOF mid-frame: first asserted at row 2 col 1 -> err_count=1, that beat written to addr 0, the following 11 beats to addr 1..11, frame_done once.
- Leading garbage plus reset: 5 beats without first -> no writes, err_count=0. Assert resetn=0 mid-frame with 2 pending writes -> wr_en=0 the next cycle, FIFO empty, s_ready=0 during reset and 1 the cycle after release.
- PIXEL_SINK_DOUBLE_BUFFER_EN: two clean frames with swap_ok=1 -> frame 0 written with addr MSB=0, frame 1 with MSB=1. With swap_ok=0 after frame 0 -> s_ready stays 0 until swap_ok=1.

Source files
------------

// File: rtl/pixel_stream_sink.sv
// rtl/pixel_stream_sink.sv - raster pixel stream sink: framing check, skid buffer, framebuffer writes
//
// Receives a raster pixel stream framed by s_first (start of frame) and
// s_lastx (end of line), checks the framing, and turns every accepted beat
// into a linear framebuffer write at row*X_SIZE+col. A framing error
// discards the offending beat and drops input until the next s_first; a
// s_first in the middle of a frame restarts the frame at address 0.
//
// Optional build macro: PIXEL_SINK_DOUBLE_BUFFER_EN (two framebuffer banks,
// wr_addr gains a bank-select MSB, fb_sel/swap_ok added).
//
// Ports:
//   clk, resetn          clock, synchronous active-low reset
//   swap_ok              (double buffer only) display allows the bank swap
//   fb_sel               (double buffer only) bank currently being written
//   s_data/s_first/s_lastx/s_valid/s_ready   pixel stream input
//   wr_en/wr_addr/wr_data/wr_ready           frame-store write port
//   frame_done           pulse when the final pixel of a frame is written
//   err_pulse            pulse on each framing error
//   err_count            saturating framing-error count

module pixel_stream_sink #(
  parameter int X_SIZE = 1024,
  parameter int Y_SIZE = 1024,
  parameter int DATA_W = 24,
  parameter int ADDR_W = 20
) (
  input  logic              clk,
  input  logic              resetn,
`ifdef PIXEL_SINK_DOUBLE_BUFFER_EN
  input  logic              swap_ok,
  output logic              fb_sel,
`endif
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_first,
  input  logic              s_lastx,
  input  logic              s_valid,
  output logic              s_ready,
  output logic              wr_en,
`ifdef PIXEL_SINK_DOUBLE_BUFFER_EN
  output logic [ADDR_W:0]   wr_addr,
`else
  output logic [ADDR_W-1:0] wr_addr,
`endif
  output logic [DATA_W-1:0] wr_data,
  input  logic              wr_ready,
  output logic              frame_done,
  output logic              err_pulse,
  output logic [15:0]       err_count
);

  localparam int CW = (X_SIZE > 1) ? $clog2(X_SIZE) : 1;
  localparam int RW = (Y_SIZE > 1) ? $clog2(Y_SIZE) : 1;
  localparam logic [CW-1:0]     COL_LAST = CW'(X_SIZE - 1);
  localparam logic [RW-1:0]     ROW_LAST = RW'(Y_SIZE - 1);
  localparam logic [CW-1:0]     COL_ONE  = CW'(1);
  localparam logic [RW-1:0]     ROW_ONE  = RW'(1);
  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

  typedef enum logic {
    WAIT_SOF = 1'b0,
    ACTIVE   = 1'b1
  } state_t;

  state_t            state, state_n;
  logic [CW-1:0]     col, col_n, col_e;
  logic [RW-1:0]     row, row_n, row_e;
  logic [ADDR_W-1:0] addr, addr_n, addr_e;

  logic              acc;
  logic              push;
  logic              push_last;
  logic              err;
  logic              pop;
  logic              hold_off;
  logic              s_ready_q;

  // Two-entry skid buffer; each entry carries data, address and the
  // last-of-frame tag.
  logic [DATA_W-1:0] fifo_data [2];
  logic [ADDR_W-1:0] fifo_addr [2];
  logic [1:0]        fifo_last;
  logic              wr_ptr, rd_ptr;
  logic [1:0]        count, count_n;
  logic [ADDR_W-1:0] head_addr;
  logic              head_last;

  assign acc = s_valid & s_ready;

  // ---------------------------------------------------------------------
  // Framing FSM
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state <= WAIT_SOF;
      col   <= '0;
      row   <= '0;
      addr  <= '0;
    end else begin
      state <= state_n;
      col   <= col_n;
      row   <= row_n;
      addr  <= addr_n;
    end
  end

  // A first beat is treated as sitting at (0,0) and then goes through the
  // same line checks as any other beat, which makes first+lastx legal when
  // X_SIZE==1. The address runs as a counter because raster order makes
  // row*X_SIZE+col simply the next linear word.
  always_comb begin
    state_n   = state;
    col_n     = col;
    row_n     = row;
    addr_n    = addr;
    push      = 1'b0;
    push_last = 1'b0;
    err       = 1'b0;
    col_e     = col;
    row_e     = row;
    addr_e    = addr;

    if (acc) begin
      if (s_first) begin
        col_e  = '0;
        row_e  = '0;
        addr_e = '0;
        err    = (state == ACTIVE);
      end

      if ((state == ACTIVE) || s_first) begin
        if (s_lastx != (col_e == COL_LAST)) begin
          // early or missing end-of-line
          err     = 1'b1;
          state_n = WAIT_SOF;
        end else begin
          push   = 1'b1;
          addr_n = addr_e + ADDR_ONE;
          if (col_e == COL_LAST) begin
            col_n = '0;
            if (row_e == ROW_LAST) begin
              push_last = 1'b1;
              row_n     = '0;
              state_n   = WAIT_SOF;
            end else begin
              row_n   = row_e + ROW_ONE;
              state_n = ACTIVE;
            end
          end else begin
            col_n   = col_e + COL_ONE;
            row_n   = row_e;
            state_n = ACTIVE;
          end
        end
      end
    end
  end

  // ---------------------------------------------------------------------
  // Skid buffer and write port
  // ---------------------------------------------------------------------
  assign wr_en      = (count != 2'd0);
  assign pop        = wr_en & wr_ready;
  assign wr_data    = fifo_data[rd_ptr];
  assign head_addr  = fifo_addr[rd_ptr];
  assign head_last  = fifo_last[rd_ptr];
  assign frame_done = pop & head_last;

  always_comb begin
    count_n = count;
    case ({push, pop})
      2'b10:   count_n = count + 2'd1;
      2'b01:   count_n = count - 2'd1;
      default: count_n = count;
    endcase
  end

  // The head entry is only replaced by a pop, so wr_addr/wr_data stay put
  // while the frame store stalls. s_ready can never overflow the buffer:
  // it was computed from the occupancy this cycle starts with.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      count     <= 2'd0;
      wr_ptr    <= 1'b0;
      rd_ptr    <= 1'b0;
      s_ready_q <= 1'b0;
      fifo_last <= 2'b00;
      for (int i = 0; i < 2; i++) begin
        fifo_data[i] <= '0;
        fifo_addr[i] <= '0;
      end
    end else begin
      count     <= count_n;
      s_ready_q <= (count_n < 2'd2);
      if (push) begin
        fifo_data[wr_ptr] <= s_data;
        fifo_addr[wr_ptr] <= addr_e;
        fifo_last[wr_ptr] <= push_last;
        wr_ptr            <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Error reporting
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!resetn) begin
      err_pulse <= 1'b0;
      err_count <= 16'd0;
    end else begin
      err_pulse <= err;
      if (err && (err_count != 16'hFFFF)) begin
        err_count <= err_count + 16'd1;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Bank selection
  // ---------------------------------------------------------------------
`ifdef PIXEL_SINK_DOUBLE_BUFFER_EN
  logic swap_pending;
  logic last_inflight;
  logic swap_req;

  assign swap_req = frame_done | swap_pending;

  // last_inflight covers the gap between accepting the final pixel and its
  // write completing, so a new frame cannot start in the old bank before
  // the swap is even requested.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      fb_sel        <= 1'b0;
      swap_pending  <= 1'b0;
      last_inflight <= 1'b0;
    end else begin
      if (push_last) begin
        last_inflight <= 1'b1;
      end else if (frame_done) begin
        last_inflight <= 1'b0;
      end
      if (swap_req && swap_ok) begin
        fb_sel       <= ~fb_sel;
        swap_pending <= 1'b0;
      end else if (frame_done) begin
        swap_pending <= 1'b1;
      end
    end
  end

  assign hold_off = (state == WAIT_SOF) & (swap_pending | last_inflight);
  assign wr_addr  = {fb_sel, head_addr};
`else
  assign hold_off = 1'b0;
  assign wr_addr  = head_addr;
`endif

  assign s_ready = s_ready_q & ~hold_off;

endmodule
